// File: rtl/dds_sweep_if.sv
// Command/configuration and status bundle between a sweep controller and its host.
// The host drives the command side; the controller drives the frequency word and status.
interface dds_sweep_if #(
    parameter int W  = 10,
    parameter int DW = 16
);
    logic          sample_pulse;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [W-1:0]  f_a;
    logic [W-1:0]  f_b;
    logic [W-1:0]  step;
    logic [DW-1:0] dwell;

    logic [W-1:0]  phase_inc;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    modport master (
        output sample_pulse, start, stop, mode, f_a, f_b, step, dwell,
        input  phase_inc, busy, done, state
    );

    modport slave (
        input  sample_pulse, start, stop, mode, f_a, f_b, step, dwell,
        output phase_inc, busy, done, state
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a DDS phase accumulator: steps phase_inc between two
// latched endpoints every 'dwell' sample strobes, in single, triangle or sawtooth mode.
module dds_sweep_ctrl #(
    parameter int W  = 10,
    parameter int DW = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    dds_sweep_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        HOLD = 2'b11
    } state_t;

    localparam logic [1:0]    M_SUP = 2'b00;
    localparam logic [1:0]    M_SDN = 2'b01;
    localparam logic [1:0]    M_TRI = 2'b10;
    localparam logic [1:0]    M_SAW = 2'b11;
    localparam logic [DW-1:0] ONE   = DW'(1);

    state_t        state_q, state_d;
    logic [W-1:0]  phase_q, phase_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  step_q, step_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [W-1:0]        in_lo, in_hi;
    logic                active, fire;
    logic [W:0]          up_sum;
    logic signed [W:0]   dn_diff;
    logic                up_at_hi, dn_at_lo, single_mode;

    assign in_lo = (bus.f_a < bus.f_b) ? bus.f_a : bus.f_b;
    assign in_hi = (bus.f_a < bus.f_b) ? bus.f_b : bus.f_a;

    assign active = (state_q == UP) || (state_q == DOWN);
    assign fire   = active && bus.sample_pulse && (cnt_q == dwell_q - ONE);

    // One extra bit on both sides so the endpoint compare sees overshoot instead of a wrap.
    assign up_sum   = {1'b0, phase_q} + {1'b0, step_q};
    assign dn_diff  = $signed({1'b0, phase_q}) - $signed({1'b0, step_q});
    assign up_at_hi = up_sum >= {1'b0, hi_q};
    assign dn_at_lo = dn_diff <= $signed({1'b0, lo_q});

    assign single_mode = (mode_q == M_SUP) || (mode_q == M_SDN);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            phase_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (bus.stop) begin
            // In IDLE these values already hold, so a stop there changes nothing.
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
        end else if (bus.start && (state_q == IDLE || state_q == HOLD)) begin
            lo_d    = in_lo;
            hi_d    = in_hi;
            step_d  = bus.step;
            mode_d  = bus.mode;
            dwell_d = (bus.dwell == '0) ? ONE : bus.dwell;
            cnt_d   = '0;
            if (bus.step == '0 || in_lo == in_hi) begin
                state_d = HOLD;
                phase_d = in_lo;
                done_d  = 1'b1;
            end else if (bus.mode == M_SDN) begin
                state_d = DOWN;
                phase_d = in_hi;
            end else begin
                state_d = UP;
                phase_d = in_lo;
            end
        end else if (active && bus.sample_pulse) begin
            if (!fire) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = '0;
                if (state_q == UP) begin
                    if (mode_q == M_SAW && phase_q == hi_q) begin
                        phase_d = lo_q;
                    end else if (up_at_hi) begin
                        phase_d = hi_q;
                        if (single_mode) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else if (mode_q == M_TRI) begin
                            state_d = DOWN;
                        end
                    end else begin
                        phase_d = up_sum[W-1:0];
                    end
                end else begin
                    if (dn_at_lo) begin
                        phase_d = lo_q;
                        if (single_mode) begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else begin
                            state_d = UP;
                        end
                    end else begin
                        phase_d = dn_diff[W-1:0];
                    end
                end
            end
        end
    end

    assign bus.phase_inc = phase_q;
    assign bus.state     = state_q;
    assign bus.busy      = active;
    assign bus.done      = done_q;
endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter: W, 10, width of frequency words (matches the phase accumulator increment).
REQ-002 Parameter: DW, 16, width of the dwell count.
REQ-003 Port: CLOCK_50, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 Port: RESET, input, 1, asynchronous active-high reset.
REQ-005 Port: sample_pulse, input, 1, one-cycle sample-rate strobe from the clock divider.
REQ-006 Port: start, input, 1, one-cycle command pulse that begins a sweep.
REQ-007 Port: stop, input, 1, one-cycle command pulse that aborts to IDLE.
REQ-008 Port: mode, input, 2, sweep mode: 00 single-up, 01 single-down, 10 triangle, 11 sawtooth.
REQ-009 Port: f_a and f_b, input, W each, sweep endpoints in either order.
REQ-010 Port: step, input, W, frequency increment per dwell period.
REQ-011 Port: dwell, input, DW, sample_pulse count per frequency step.
REQ-012 Port: phase_inc, output, W, registered frequency word to the phase accumulator.
REQ-013 Port: busy, output, 1, high in UP or DOWN.
REQ-014 Port: done, output, 1, one-cycle pulse at the end of a single sweep.
REQ-015 Port: state, output, 2, encoding IDLE=00, UP=01, DOWN=10, HOLD=11.

Function
REQ-016 On start in IDLE or HOLD, the block shall latch lo=min(f_a,f_b), hi=max(f_a,f_b), step, mode and an effective dwell of max(dwell,1); later input changes shall be ignored until the next start.
REQ-017 Start state: one cycle after start, enter DOWN with phase_inc=hi if mode=01; otherwise enter UP with phase_inc=lo.
REQ-018 The dwell counter shall clear on start, increment on each sample_pulse, and fire on the sample_pulse that reaches dwell-1; firing clears the counter.
REQ-019 On fire in UP, compute nxt=phase_inc+step in W+1 bits; if nxt>=hi, set phase_inc=hi and take the end action, else set phase_inc=nxt.
REQ-020 On fire in DOWN, compute nxt=phase_inc-step in W+1 bits signed; if nxt<=lo, set phase_inc=lo and take the end action, else set phase_inc=nxt.
REQ-021 Single modes (00/01): the end action shall go to HOLD, keep phase_inc at the endpoint, and assert done for exactly one cycle.
REQ-022 Triangle mode (10): at hi, UP shall go to DOWN; at lo, DOWN shall go to UP; done is never asserted.
REQ-023 Sawtooth mode (11): at hi, the next fire shall reload phase_inc=lo and stay in UP; done is never asserted.
REQ-024 If step=0 or lo=hi, start shall enter HOLD with phase_inc=lo and pulse done one cycle later.
REQ-025 phase_inc shall change only on start, on a fire cycle's next edge, or on entry to IDLE.
REQ-026 On entry to IDLE via stop, phase_inc shall become 0 and the dwell counter shall clear.
REQ-027 Stop in IDLE shall have no effect.
REQ-028 Start while in UP or DOWN shall be ignored.
REQ-029 If start and stop are asserted together, stop shall win.
REQ-030 HOLD shall persist until stop (go to IDLE) or start (restart per REQ-016).
REQ-031 Arithmetic shall never wrap: phase_inc stays within [lo,hi] whenever busy or in HOLD.

Reset
REQ-032 While RESET is high, the block shall hold state=IDLE, phase_inc=0, busy=0, done=0, the dwell counter at 0, and latched registers at 0, independent of the clock.
REQ-033 Reset asserted mid-sweep shall abort immediately with no done pulse; after release, the block shall wait in IDLE for start.

Verification
REQ-034 Single-up: f_a=100, f_b=130, step=10, dwell=2, mode=00, start -> phase_inc 100,110,120,130 changing every 2nd sample_pulse; HOLD; one done pulse; busy low after.
REQ-035 Triangle: lo=0, hi=25, step=10, dwell=1, mode=10 -> phase_inc sequence 0,10,20,25,15,5,0,10... and no done pulse.
REQ-036 Sawtooth with reversed endpoints: f_a=50, f_b=20, step=15, dwell=1, mode=11 -> phase_inc 20,35,50,20,35...
REQ-037 Boundaries: step=0 -> HOLD at lo with done after 1 cycle; dwell=0 behaves as dwell=1; hi=1023 with step=1000 clamps to 1023 with no wrap.
REQ-038 Control: stop and start in the same cycle during UP -> IDLE with phase_inc=0; start during UP -> ignored.
REQ-039 Reset: RESET asserted mid-sweep asynchronously (between clock edges) -> outputs return to reset values immediately with no done pulse.
